// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 4166;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through byte FIFO
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy count
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a FWFT byte FIFO with sticky error flags
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          rx_line_uart,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          rx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rxs;
  rx_state_e            state_q;
  logic [TW-1:0]        timer_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 busy_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 bit_end;
  logic                 stop_sample;
  logic                 push;
  logic                 ferr_set;
  logic                 ovr_set;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_line_uart;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // The stop-sample edge is also the FIFO write edge, so the byte is visible the following cycle
  assign bit_end     = (timer_q == BIT_LAST);
  assign stop_sample = (state_q == ST_STOP) && bit_end;
  assign push        = stop_sample && rxs;
  assign ferr_set    = stop_sample && !rxs;
  assign ovr_set     = push && fifo_full && !rd_en;

  // Receive FSM: start validation at mid-bit, then one sample per bit period
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_q <= ST_START;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (timer_q == HALF_LAST) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            if (!rxs) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            timer_q   <= '0;
            shift_q   <= {rxs, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            timer_q <= '0;
            if (rxs) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_BREAK;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status flags; a set event outranks a simultaneous clear
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ferr_set)      frame_err_q <= 1'b1;
      else if (clr_err)  frame_err_q <= 1'b0;
      if (ovr_set)       overrun_q   <= 1'b1;
      else if (clr_err)  overrun_q   <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (rd_en),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB  = 50;
  localparam int HALF = CPB / 2;
  // Negedges after the start-bit negedge at which the stop-sample edge is next
  localparam int STOP_NEG = 2 + HALF + 9 * CPB;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       rx_line_uart;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int n_cmp = 0;
  int n_mis = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .rx_line_uart (rx_line_uart),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .fifo_count   (fifo_count),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  always #1 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge at the end of the stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb);
    rx_line_uart = 1'b0;
    repeat (cpb) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx_line_uart = b[i];
      repeat (cpb) @(negedge clk_in);
    end
    rx_line_uart = stop_bit;
    repeat (cpb) @(negedge clk_in);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, rx_valid, 1);
    check_eq({tag, "_data"}, rx_data, exp);
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk_in);
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] pb;
    rst = 1'b0; rx_line_uart = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk_in);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_ovr", overrun, 0);
    check_eq("rst_busy", rx_busy, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk_in);

    // Pop on an empty FIFO is ignored
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
    check_eq("empty_pop_count", fifo_count, 0);
    check_eq("empty_pop_valid", rx_valid, 0);

    // Three back-to-back frames, with exact push latency on the first
    fork
      send_frame(8'h05, 1'b1, CPB);
      begin
        repeat (STOP_NEG) @(negedge clk_in);
        check_eq("push_lat_before", fifo_count, 0);
        @(negedge clk_in);
        check_eq("push_lat_after", fifo_count, 1);
        check_eq("idle_after_stop", rx_busy, 0);
      end
    join
    send_frame(8'h03, 1'b1, CPB);
    send_frame(8'h0C, 1'b1, CPB);
    check_eq("b2b_count", fifo_count, 3);
    check_eq("b2b_ferr", frame_err, 0);
    check_eq("b2b_ovr", overrun, 0);
    pop_check("b2b_0", 8'h05);
    pop_check("b2b_1", 8'h03);
    pop_check("b2b_2", 8'h0C);
    check_eq("b2b_empty", rx_valid, 0);

    // Baud mismatch of roughly +-2%
    send_frame(8'h96, 1'b1, CPB - 1);
    send_frame(8'h69, 1'b1, CPB + 1);
    pop_check("tol_fast", 8'h96);
    pop_check("tol_slow", 8'h69);

    // Start glitch shorter than half a bit
    repeat (10) @(negedge clk_in);
    rx_line_uart = 1'b0;
    repeat (4) @(negedge clk_in);
    check_eq("glitch_busy", rx_busy, 1);
    repeat (2) @(negedge clk_in);
    rx_line_uart = 1'b1;
    repeat (HALF + 3 - 6) @(negedge clk_in);
    check_eq("glitch_idle", rx_busy, 0);
    check_eq("glitch_count", fifo_count, 0);

    // Framing error followed by a held-low line, then a good frame
    send_frame(8'h55, 1'b0, CPB);
    repeat (3 * CPB) @(negedge clk_in);
    check_eq("ferr_set", frame_err, 1);
    check_eq("ferr_count", fifo_count, 0);
    check_eq("ferr_break_busy", rx_busy, 1);
    rx_line_uart = 1'b1;
    repeat (5) @(negedge clk_in);
    check_eq("ferr_break_exit", rx_busy, 0);
    send_frame(8'hA3, 1'b1, CPB);
    check_eq("ferr_sticky", frame_err, 1);
    pop_check("ferr_next", 8'hA3);
    pulse_clr();
    check_eq("ferr_clear", frame_err, 0);

    // Overrun: five frames, no pops
    for (int i = 0; i < 5; i++) begin
      pb = 8'h11 + 8'(i);
      send_frame(pb, 1'b1, CPB);
    end
    check_eq("ovr_count", fifo_count, 4);
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_ferr", frame_err, 0);
    pulse_clr();
    check_eq("ovr_clear", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      pb = 8'h11 + 8'(i);
      pop_check("ovr_pop", pb);
    end
    check_eq("ovr_empty", rx_valid, 0);

    // Full FIFO: pop on the stop-sample cycle lets the new byte in
    for (int i = 0; i < 4; i++) begin
      pb = 8'h21 + 8'(i);
      send_frame(pb, 1'b1, CPB);
    end
    check_eq("fpp_full", fifo_count, 4);
    fork
      send_frame(8'h25, 1'b1, CPB);
      begin
        repeat (STOP_NEG) @(negedge clk_in);
        rd_en = 1'b1;
        @(negedge clk_in);
        rd_en = 1'b0;
      end
    join
    check_eq("fpp_ovr", overrun, 0);
    check_eq("fpp_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      pb = 8'h22 + 8'(i);
      pop_check("fpp_pop", pb);
    end

    // Reset in the middle of data bit 4 with a byte already queued
    send_frame(8'h5A, 1'b1, CPB);
    check_eq("rmf_pre_count", fifo_count, 1);
    pb = 8'h3C;
    rx_line_uart = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      rx_line_uart = pb[i];
      repeat (CPB) @(negedge clk_in);
    end
    rx_line_uart = pb[4];
    repeat (HALF) @(negedge clk_in);
    rst = 1'b0;
    rx_line_uart = 1'b1;
    repeat (3) @(negedge clk_in);
    check_eq("rmf_data", rx_data, 0);
    check_eq("rmf_valid", rx_valid, 0);
    check_eq("rmf_count", fifo_count, 0);
    check_eq("rmf_busy", rx_busy, 0);
    rst = 1'b1;
    repeat (CPB * 6) @(negedge clk_in);
    check_eq("rmf_no_push", fifo_count, 0);
    check_eq("rmf_idle", rx_busy, 0);
    send_frame(8'h7E, 1'b1, CPB);
    pop_check("rmf_next", 8'h7E);
    check_eq("rmf_empty", rx_valid, 0);
    check_eq("final_ferr", frame_err, 0);
    check_eq("final_ovr", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the single-cycle core. It recovers 8N1 UART frames from the asynchronous `rx_line_uart` pin and buffers the received bytes in a small first-word-fall-through FIFO. The core's UART peripheral logic pops bytes from that FIFO. Framing errors and overruns are flagged in sticky status bits that the core reads and clears.

## Interface
- `CLKS_PER_BIT`, default 4166: clock cycles per bit period (2 ns clock, 8333 ns bit); legal range ≥ 4.
- `FIFO_DEPTH`, default 4: byte entries; must be a power of 2, ≥ 2.

Ports:
- `clk_in` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx_line_uart` input 1: raw serial line; idle high; asynchronous to `clk_in`.
- `rd_en` input 1: pop request for the head byte.
- `clr_err` input 1: clears `frame_err` and `overrun` (one-cycle pulse).
- `rx_data` output 8: head byte of the FIFO; valid only while `rx_valid`=1.
- `rx_valid` output 1: FIFO not empty.
- `fifo_count` output log2(FIFO_DEPTH)+1: bytes currently stored.
- `frame_err` output 1: sticky; stop bit sampled low.
- `overrun` output 1: sticky; a byte was dropped because the FIFO was full.
- `rx_busy` output 1: FSM is not in IDLE.

## Operation
- **Input sync:** `rx_line_uart` passes through a 2-flop synchronizer (reset value 1). The FSM sees only the synced signal `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. A single bit-timer counts 0..CLKS_PER_BIT-1, and a 3-bit counter tracks the bit index.
- **IDLE:** when `rxs`=0, go to START and clear the timer.
- **START:** when the timer reaches CLKS_PER_BIT/2 (integer division), sample `rxs`.
  - 0: go to DATA.
  - 1: glitch; return to IDLE with nothing pushed.
- **DATA:** every CLKS_PER_BIT cycles, sample `rxs` and shift it into the shift register LSB-first. After the 8th sample, go to STOP.
- **STOP:** after CLKS_PER_BIT cycles, sample `rxs`.
  - 1: push the byte, then go to IDLE.
  - 0: set `frame_err`, discard the byte, go to BREAK.
- **BREAK:** wait for `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- **Push/pop rules:**
  - Push when full: byte dropped, `overrun` set, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both occur; no overrun.
  - Pop when empty: ignored; pointers and count unchanged.
- **Status clear:** `clr_err` clears both sticky flags. If a set event occurs in the same cycle as `clr_err`, the set wins.
- **Reset values:** `rx_data` 0 (storage cleared), `rx_valid` 0, `fifo_count` 0, `frame_err` 0, `overrun` 0, `rx_busy` 0, FSM in IDLE, synchronizer outputs 1.
- **Reset mid-frame:** the partial byte is lost and no push occurs. After reset the FSM restarts in IDLE, so if the line is low at that point it is treated as a new start bit.

## Timing
- **Synchronizer delay:** 2 cycles from the pin to `rxs`.
- **Sample points:** start check at T0 + CLKS_PER_BIT/2, where T0 is the cycle `rxs` first reads 0. Data bit k is sampled at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT, and stop at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- **Push latency:** the push is registered on the stop-sample edge. `rx_valid` and `fifo_count` update in the following cycle.
- **FIFO read:** first-word-fall-through. `rx_data` is combinational from the head entry. A pop on edge N exposes the next entry after edge N.
- **Throughput:** back-to-back frames are accepted with zero idle time after the stop sample. The FSM is in IDLE one cycle after the stop sample.
- **Tolerance:** reception must succeed with a ±2% baud mismatch.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - `DATA_BITS`=8.
  - Default `CLKS_PER_BIT`.
- **Sub-module `sync_fifo`:**
  - Parameterised width and depth.
  - Ports: push, pop, full, empty, count, and FWFT head.
  - Instantiated once; the receive FSM stays in the top module.

## Test plan
- **Three back-to-back frames:** idle high, then data bits (LSB first) 1,0,1,0,0,0,0,0 / 1,1,0,0,0,0,0,0 / 0,0,1,1,0,0,0,0, each framed by a start bit and stop=1 at 8333 ns per bit. Expect `fifo_count`=3 and pops returning 0x05, 0x03, 0x0C in that order, with no error flags.
- **Start glitch:** line low for 1000 ns, then high. Expect no push, FSM back in IDLE, `rx_busy` low within CLKS_PER_BIT/2+3 cycles.
- **Framing error:** frame 0x55 with stop=0, line held low 20 µs, then high. Expect `frame_err`=1, FIFO empty, and no new frame until the line returns high. A following valid 0xA3 frame is received correctly.
- **Overrun:** 5 frames (0x11..0x15) with no pops. Expect `fifo_count`=4, `overrun`=1, and contents 0x11..0x14. Asserting `clr_err` clears the flag on the next cycle.
- **Full push with pop:** FIFO full, `rd_en` asserted on the stop-sample cycle. Expect `overrun`=0, count stays 4, new byte at the tail.
- **Reset mid-frame:** assert `rst` low during data bit 4, then release. Expect all outputs at reset values and no byte pushed. The next full frame (0x7E) is received correctly.
